temp_disp_sched: RTL and testbench

- Scheduler that shares the 6-digit 595 display driver between three temperature views: current, running maximum and running minimum.
- Sits between the DS18B20 sensor controller (magnitude plus sign, milli-degree resolution) and seg_595_dynamic.
- Rotates views on a dwell timer, or on a user next pulse.
- Tracks min/max and blanks the current view when sensor data goes stale.

---
 rtl/temp_disp_pkg.sv | 37 +++
 rtl/ms_tick_gen.sv | 28 ++
 rtl/temp_disp_sched.sv | 158 +++++++++++++++
 tb/tb_temp_disp_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_disp_pkg.sv
// Shared types, display constants and signed helpers for the temperature
// display scheduler.
package temp_disp_pkg;

  typedef enum logic [1:0] {
    VIEW_CUR = 2'd0,
    VIEW_MAX = 2'd1,
    VIEW_MIN = 2'd2
  } view_e;

  // Decimal-point masks: CUR/MAX/MIN differ so the user can tell views apart
  localparam logic [5:0] PT_CUR = 6'b001000;
  localparam logic [5:0] PT_MAX = 6'b001001;
  localparam logic [5:0] PT_MIN = 6'b101000;

  // Magnitude plus sign to 21-bit two's complement; -0 collapses to 0
  function automatic logic signed [20:0] to_s21(input logic [19:0] mag,
                                                input logic        neg);
    logic signed [20:0] w;
    w = {1'b0, mag};
    return neg ? -w : w;
  endfunction

  // Strict signed greater-than on 21-bit values
  function automatic logic s21_gt(input logic signed [20:0] a,
                                  input logic signed [20:0] b);
    return a > b;
  endfunction

  // Magnitude of a 21-bit value, for the display data bus
  function automatic logic [19:0] s21_mag(input logic signed [20:0] v);
    logic [20:0] a;
    a = v[20] ? -v : v;
    return a[19:0];
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: one-cycle pulse every CLK_FREQ/1000 cycles.
module ms_tick_gen #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic ms_tick
);

  localparam int DIV = CLK_FREQ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign ms_tick = (r_cnt == CW'(DIV - 1));

  // Free-running prescaler, wraps on the tick
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (ms_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/temp_disp_sched.sv
// Temperature display scheduler: rotates CUR/MAX/MIN views onto one
// 6-digit display, tracks running min/max and blanks stale current data.
module temp_disp_sched
  import temp_disp_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DWELL_MS    = 2000,
  parameter int STALE_MS    = 3000,
  parameter int AUTO_ROTATE = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        temp_vld,
  input  logic [19:0] temp_data,
  input  logic        temp_sign,
  input  logic        key_next,
  input  logic        key_clr,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en,
  output logic [1:0]  view,
  output logic        stale
);

  // Interface contract: temp_vld, key_next and key_clr are single-cycle
  // strobes with no backpressure; every strobe is consumed on the cycle it
  // is high. The display outputs are level signals, valid every cycle.

  localparam int DW = $clog2(DWELL_MS + 1);
  localparam int SW = $clog2(STALE_MS + 1);

  logic                w_tick;
  logic signed [20:0]  w_sample;
  logic                w_dwell_exp;
  logic                w_advance;

  logic                r_have;
  logic signed [20:0]  r_cur;
  logic signed [20:0]  r_min;
  logic signed [20:0]  r_max;
  logic [SW-1:0]       r_stale_cnt;
  logic                r_stale;
  logic [DW-1:0]       r_dwell_cnt;
  view_e               r_view;
  logic [19:0]         r_data;
  logic [5:0]          r_point;
  logic                r_sign;
  logic                r_seg_en;

  ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .ms_tick (w_tick)
  );

  assign w_sample    = to_s21(temp_data, temp_sign);
  assign w_dwell_exp = (AUTO_ROTATE != 0) && w_tick &&
                       (r_dwell_cnt == DW'(DWELL_MS - 1));
  // Key and dwell expiry on the same cycle still yield a single step
  assign w_advance   = r_have && (key_next || w_dwell_exp);

  // Current sample capture and running min/max tracking
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_have <= 1'b0;
      r_cur  <= '0;
      r_min  <= '0;
      r_max  <= '0;
    end else if (temp_vld) begin
      r_cur  <= w_sample;
      r_have <= 1'b1;
      if (!r_have || key_clr) begin
        r_min <= w_sample;
        r_max <= w_sample;
      end else begin
        if (s21_gt(w_sample, r_max)) r_max <= w_sample;
        if (s21_gt(r_min, w_sample)) r_min <= w_sample;
      end
    end else if (key_clr && r_have) begin
      r_min <= r_cur;
      r_max <= r_cur;
    end
  end

  // Staleness: count ms since the last sample, saturating at STALE_MS
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_stale_cnt <= '0;
      r_stale     <= 1'b0;
    end else if (temp_vld) begin
      r_stale_cnt <= '0;
      r_stale     <= 1'b0;
    end else if (r_have && w_tick && (r_stale_cnt != SW'(STALE_MS))) begin
      r_stale_cnt <= r_stale_cnt + 1'b1;
      if (r_stale_cnt == SW'(STALE_MS - 1)) r_stale <= 1'b1;
    end
  end

  // View FSM with dwell timer; parked on CUR until the first sample arrives
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_view      <= VIEW_CUR;
      r_dwell_cnt <= '0;
    end else if (!r_have) begin
      r_view      <= VIEW_CUR;
      r_dwell_cnt <= '0;
    end else if (w_advance) begin
      r_dwell_cnt <= '0;
      case (r_view)
        VIEW_CUR: r_view <= VIEW_MAX;
        VIEW_MAX: r_view <= VIEW_MIN;
        default:  r_view <= VIEW_CUR;
      endcase
    end else if (w_tick && (r_dwell_cnt != DW'(DWELL_MS - 1))) begin
      r_dwell_cnt <= r_dwell_cnt + 1'b1;
    end
  end

  // Registered output mux toward the 595 display driver
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_data   <= '0;
      r_point  <= PT_CUR;
      r_sign   <= 1'b0;
      r_seg_en <= 1'b0;
    end else begin
      case (r_view)
        VIEW_MAX: begin
          r_data   <= s21_mag(r_max);
          r_sign   <= r_max[20];
          r_point  <= PT_MAX;
          r_seg_en <= r_have;
        end
        VIEW_MIN: begin
          r_data   <= s21_mag(r_min);
          r_sign   <= r_min[20];
          r_point  <= PT_MIN;
          r_seg_en <= r_have;
        end
        default: begin
          r_data   <= s21_mag(r_cur);
          r_sign   <= r_cur[20];
          r_point  <= PT_CUR;
          r_seg_en <= r_have && !r_stale;
        end
      endcase
    end
  end

  assign data   = r_data;
  assign point  = r_point;
  assign sign   = r_sign;
  assign seg_en = r_seg_en;
  assign view   = r_view;
  assign stale  = r_stale;

endmodule

// File: tb/tb_temp_disp_sched.sv
// Bench for temp_disp_sched: directed scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural model of the display.
module tb_temp_disp_sched;

  localparam int CLK_FREQ = 4000;
  localparam int DWELL_MS = 3;
  localparam int STALE_MS = 5;
  localparam int TICK     = CLK_FREQ / 1000;

  // ---------------- clock / reset / signals ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        temp_vld;
  logic [19:0] temp_data;
  logic        temp_sign;
  logic        key_next;
  logic        key_clr;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [1:0]  view;
  logic        stale;

  always #5 sys_clk = ~sys_clk;

  temp_disp_sched #(
    .CLK_FREQ(CLK_FREQ), .DWELL_MS(DWELL_MS),
    .STALE_MS(STALE_MS), .AUTO_ROTATE(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .temp_vld(temp_vld),
    .temp_data(temp_data), .temp_sign(temp_sign), .key_next(key_next),
    .key_clr(key_clr), .data(data), .point(point), .sign(sign),
    .seg_en(seg_en), .view(view), .stale(stale)
  );

  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Values are plain signed integers; time is counted in cycles and ms.
  bit m_have, m_stale;
  int m_cur, m_min, m_max, m_view, m_dwell, m_stale_ms, m_cyc;

  always @(posedge sys_clk) begin
    int s, o_val;
    bit tick, adv, o_en, o_neg;
    logic [5:0] o_pt;
    logic [19:0] o_mag;
    if (sys_rst) begin
      m_have = 0; m_stale = 0; m_cur = 0; m_min = 0; m_max = 0;
      m_view = 0; m_dwell = 0; m_stale_ms = 0; m_cyc = 0;
      exp_q.push_back({2'd0, 1'b0, 1'b0, 1'b0, 6'b001000, 20'd0});
    end else begin
      // the display shows what was held before this edge
      case (m_view)
        1:       begin o_val = m_max; o_pt = 6'b001001; o_en = m_have; end
        2:       begin o_val = m_min; o_pt = 6'b101000; o_en = m_have; end
        default: begin o_val = m_cur; o_pt = 6'b001000; o_en = m_have && !m_stale; end
      endcase
      o_neg = (o_val < 0);
      o_mag = 20'(o_neg ? -o_val : o_val);
      tick = ((m_cyc % TICK) == TICK - 1);
      m_cyc++;
      // view rotation: ms elapsed since last change, or a key
      if (!m_have) begin
        m_view = 0; m_dwell = 0;
      end else begin
        adv = key_next || (tick && (m_dwell + 1 >= DWELL_MS));
        if (adv) begin
          m_view = (m_view + 1) % 3; m_dwell = 0;
        end else if (tick && m_dwell < DWELL_MS - 1) begin
          m_dwell++;
        end
      end
      // staleness: ms since last sample
      if (temp_vld) begin
        m_stale_ms = 0; m_stale = 0;
      end else if (m_have && tick && m_stale_ms < STALE_MS) begin
        m_stale_ms++;
        if (m_stale_ms == STALE_MS) m_stale = 1;
      end
      // samples and min/max
      s = temp_sign ? -int'(temp_data) : int'(temp_data);
      if (temp_vld) begin
        if (!m_have || key_clr) begin m_min = s; m_max = s; end
        else begin
          if (s > m_max) m_max = s;
          if (s < m_min) m_min = s;
        end
        m_cur = s; m_have = 1;
      end else if (key_clr && m_have) begin
        m_min = m_cur; m_max = m_cur;
      end
      exp_q.push_back({2'(m_view), m_stale, o_en, o_neg, o_pt, o_mag});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge sys_clk) begin
    logic [30:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data",   data,   e[19:0]);
      chk("point",  point,  e[25:20]);
      chk("sign",   sign,   e[26]);
      chk("seg_en", seg_en, e[27]);
      chk("stale",  stale,  e[28]);
      chk("view",   view,   e[30:29]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send(input int mag, input bit neg, input bit clr);
    @(negedge sys_clk);
    temp_vld = 1'b1; temp_data = 20'(mag); temp_sign = neg; key_clr = clr;
    @(negedge sys_clk);
    temp_vld = 1'b0; key_clr = 1'b0;
  endtask

  task automatic pulse_next();
    @(negedge sys_clk);
    key_next = 1'b1;
    @(negedge sys_clk);
    key_next = 1'b0;
  endtask

  task automatic wait_view(input logic [1:0] v, input int budget);
    int n = 0;
    while (view !== v && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (view !== v) begin
      checks++; errors++;
      $display("FAIL wait_view actual=%0d required=%0d (timeout)", view, v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"},   data,   0);
    chk({tag, "_point"},  point,  6'b001000);
    chk({tag, "_sign"},   sign,   0);
    chk({tag, "_seg_en"}, seg_en, 0);
    chk({tag, "_view"},   view,   0);
    chk({tag, "_stale"},  stale,  0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [1:0] v_exp;
    sys_rst = 1'b1; temp_vld = 1'b0; temp_data = '0; temp_sign = 1'b0;
    key_next = 1'b0; key_clr = 1'b0;

    // 1: reset, idle 20 ms with ignored keys
    cycles(3);
    check_reset_outputs("rst");
    sys_rst = 1'b0;
    cycles(30); pulse_next(); cycles(30); pulse_next(); cycles(16);
    chk("idle_view", view, 0);
    chk("idle_seg_en", seg_en, 0);
    chk("idle_stale", stale, 0);

    // 2: three samples, latency and MAX/MIN contents
    send(25500, 0, 0);
    chk("first_t1_data", data, 0);
    cycles(1);
    chk("first_t2_data", data, 25500);
    chk("first_t2_seg_en", seg_en, 1);
    send(3125, 1, 0);
    send(30000, 0, 0);
    wait_view(2'd1, 60); cycles(1);
    chk("max_data", data, 30000);
    chk("max_sign", sign, 0);
    chk("max_point", point, 6'b001001);
    wait_view(2'd2, 60); cycles(1);
    chk("min_data", data, 3125);
    chk("min_sign", sign, 1);
    chk("min_point", point, 6'b101000);

    // 3: key_next landing on the dwell-expiry cycle
    wait_view(2'd0, 60);
    n = 0;
    while (!(m_have && (m_cyc % TICK) == TICK - 1 && m_dwell == DWELL_MS - 1) && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL expiry_wait actual=timeout required=expiry");
    end
    v_exp = 2'((m_view + 1) % 3);
    key_next = 1'b1;
    @(negedge sys_clk);
    key_next = 1'b0;
    chk("adv_once", view, v_exp);
    cycles(11);
    chk("dwell_restart", view, v_exp);

    // 4: staleness and recovery
    send(12345, 0, 0);
    cycles(24);
    chk("stale_set", stale, 1);
    send(500, 1, 0);
    chk("stale_clr", stale, 0);

    // 5: key_clr with a sample, then -0 and +0
    send(20000, 0, 1);
    wait_view(2'd1, 60); cycles(1);
    chk("clr_max", data, 20000);
    send(0, 1, 0);
    send(0, 0, 0);
    wait_view(2'd2, 60); cycles(1);
    chk("zero_min", data, 0);
    chk("zero_sign", sign, 0);

    // 6: reset during MIN view, then re-initialise
    wait_view(2'd2, 60);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs("midrst");
    sys_rst = 1'b0;
    send(7777, 1, 0);
    wait_view(2'd1, 60); cycles(1);
    chk("reinit_max", data, 7777);
    chk("reinit_max_sign", sign, 1);

    // 7: randomized traffic, bursty and quiet phases
    for (int blk = 0; blk < 20; blk++) begin
      int vld_div;
      vld_div = (blk % 3 == 0) ? 48 : 4;
      for (int c = 0; c < 100; c++) begin
        @(negedge sys_clk);
        sys_rst   = ($urandom_range(0, 499) == 0);
        temp_vld  = ($urandom_range(0, vld_div - 1) == 0);
        temp_data = 20'($urandom_range(0, 999999));
        if ($urandom_range(0, 9) == 0) temp_data = 20'($urandom_range(0, 3));
        temp_sign = $urandom_range(0, 1);
        key_next  = ($urandom_range(0, 29) == 0);
        key_clr   = ($urandom_range(0, 39) == 0);
      end
    end
    @(negedge sys_clk);
    sys_rst = 1'b0; temp_vld = 1'b0; key_next = 1'b0; key_clr = 1'b0;
    cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
